// File: rtl/mips_pkg.sv
// Shared definitions for the pipelined MIPS core: data-memory FSM states,
// datapath word width and the primary opcodes decoded by the controller.
package mips_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  // Primary opcode field (instr[31:26]) values
  localparam logic [5:0] RT   = 6'b000000;  // R-type, function in funct field
  localparam logic [5:0] ADDI = 6'b001000;
  localparam logic [5:0] SLTI = 6'b001010;
  localparam logic [5:0] LW   = 6'b100011;
  localparam logic [5:0] SW   = 6'b101011;
  localparam logic [5:0] BEQ  = 6'b000100;
  localparam logic [5:0] J    = 6'b000010;
  localparam logic [5:0] JAL  = 6'b000011;
  // JR is an R-type instruction; this is its funct field (instr[5:0])
  localparam logic [5:0] JR   = 6'b001000;

endpackage

// File: rtl/dmem_array.sv
// Single-port data memory: synchronous write, combinational read on the
// same index. Contents are deliberately not reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];

  // Commit a write to the addressed word
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/data_mem_unit.sv
// MEM-stage data-memory responder. Accepts a load/store from EX/MEM, holds
// the pipeline with Stall for LAT cycles, performs the access on the last
// stalled edge and presents a registered ReadData in the following DONE cycle.
module data_mem_unit
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int LAT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_MEM,
  input  logic              MemWrite_MEM,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WriteData,
  output logic [31:0]       ReadData,
  output logic              Stall
);

  localparam logic [3:0] LAT_M1 = 4'(LAT - 1);

  mem_state_t        state_q, state_d;
  // Stall cycles still to go in WAIT, including the current one
  logic [3:0]        count_q, count_d;
  logic              op_wr_q, op_wr_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  logic              req_s;
  logic [AW-1:0]     in_idx_s;
  logic              acc_s;
  logic              acc_wr_s;
  logic [AW-1:0]     acc_idx_s;
  logic [WORD_W-1:0] acc_wdata_s;
  logic              mem_we_s;
  logic [WORD_W-1:0] mem_rdata_s;
  logic              addr_unused_s;

  assign req_s         = MemRead_MEM | MemWrite_MEM;
  assign in_idx_s      = Addr[AW+1:2];
  assign addr_unused_s = ^{Addr[31:AW+2], Addr[1:0]};

  // A write never commits while reset is asserted, even on the LAT=1 path
  assign mem_we_s = acc_s & acc_wr_s & rst;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_dmem_array (
    .clk     (clk),
    .we_i    (mem_we_s),
    .addr_i  (acc_idx_s),
    .wdata_i (acc_wdata_s),
    .rdata_o (mem_rdata_s)
  );

  // Next-state, request latch, array access and ReadData update
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_wr_d     = op_wr_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    acc_s       = 1'b0;
    acc_wr_s    = 1'b0;
    acc_idx_s   = idx_q;
    acc_wdata_s = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_s) begin
          op_wr_d = MemWrite_MEM;
          idx_d   = in_idx_s;
          wdata_d = WriteData;
          count_d = LAT_M1;
          if (LAT == 1) begin
            acc_s       = 1'b1;
            acc_wr_s    = MemWrite_MEM;
            acc_idx_s   = in_idx_s;
            acc_wdata_s = WriteData;
            state_d     = DONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (count_q > 4'd1) begin
          count_d = count_q - 4'd1;
        end else begin
          count_d  = 4'd0;
          acc_s    = 1'b1;
          acc_wr_s = op_wr_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        // Request still visible here belongs to the instruction just served
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (acc_s && !acc_wr_s) begin
      rdata_d = mem_rdata_s;
    end else begin
      rdata_d = rdata_d;
    end
  end

  // State, counter, request latch and ReadData registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= 4'd0;
      op_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_wr_q <= op_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign ReadData = rdata_q;
  assign Stall    = rst & (((state_q == IDLE) & req_s) | (state_q == WAIT));

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench for data_mem_unit (LAT=3): the driver pushes the expected
// ReadData for each access, the monitor pops and compares in each DONE cycle.
module tb_data_mem_unit;

  localparam int LAT = 3;

  logic        clk;
  logic        rst;
  logic        MemRead_MEM;
  logic        MemWrite_MEM;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        Stall;

  data_mem_unit #(.DEPTH(256), .AW(8), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .MemRead_MEM  (MemRead_MEM),
    .MemWrite_MEM (MemWrite_MEM),
    .Addr         (Addr),
    .WriteData    (WriteData),
    .ReadData     (ReadData),
    .Stall        (Stall)
  );

  typedef struct {
    logic        chk_data;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  int          run_len = 0;

  logic [31:0] model [256];
  logic        known [256];
  logic [31:0] last_read;
  logic        last_valid;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Monitor: a DONE cycle is the first Stall-low sample after a stalled run
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      run_len = 0;
    end else if (Stall) begin
      run_len++;
    end else if (run_len != 0) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got a DONE cycle expected none");
      end else begin
        e = sb_q.pop_front();
        check32({e.name, "_stall_len"}, 32'(run_len), 32'(LAT));
        if (e.chk_data) begin
          check32({e.name, "_rdata"}, ReadData, e.data);
        end
      end
      run_len = 0;
    end
  end

  // Wait until the DONE cycle, then one more edge so the DUT is back in IDLE
  task automatic wait_done(input string nm);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (Stall && n < 20);
    if (Stall) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got Stall=1 after %0d cycles expected 0", nm, n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] wd, input string nm);
    exp_t e;
    int   idx;
    idx = int'(a[9:2]);
    e.name = nm;
    if (wr) begin
      model[idx] = wd;
      known[idx] = 1'b1;
      e.chk_data = last_valid;
      e.data     = last_read;
    end else begin
      if (rd && known[idx]) begin
        last_read  = model[idx];
        last_valid = 1'b1;
      end else begin
        last_valid = 1'b0;
      end
      e.chk_data = last_valid;
      e.data     = last_read;
    end
    sb_q.push_back(e);
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input string nm);
    push_exp(rd, wr, a, wd, nm);
    MemRead_MEM  = rd;
    MemWrite_MEM = wr;
    Addr         = a;
    WriteData    = wd;
    wait_done(nm);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      known[i] = 1'b0;
      model[i] = 32'd0;
    end
    last_read    = 32'd0;
    last_valid   = 1'b1;
    rst          = 1'b0;
    MemRead_MEM  = 1'b1;
    MemWrite_MEM = 1'b0;
    Addr         = 32'h0000_0010;
    WriteData    = 32'd0;

    // Reset held with a load request pending
    repeat (2) @(posedge clk);
    #1;
    check32("reset_stall", {31'd0, Stall}, 32'd0);
    check32("reset_rdata", ReadData, 32'd0);
    rst = 1'b1;
    #1;
    check32("release_stall", {31'd0, Stall}, 32'd1);
    push_exp(1'b1, 1'b0, Addr, WriteData, "reset_read");
    @(posedge clk);
    #1;
    check32("wait_stall", {31'd0, Stall}, 32'd1);
    wait_done("reset_read");

    // Store/load, wrap and low address bits, back-to-back loads
    access(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "st_10");
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0,         "ld_10");
    access(1'b0, 1'b1, 32'h0000_0400, 32'h1234_5678, "st_wrap");
    access(1'b1, 1'b0, 32'h0000_0003, 32'd0,         "ld_003");
    access(1'b0, 1'b1, 32'h0000_0014, 32'hCAFE_F00D, "st_14");
    access(1'b1, 1'b0, 32'h0000_0010, 32'd0,         "b2b_ld_10");
    access(1'b1, 1'b0, 32'h0000_0014, 32'd0,         "b2b_ld_14");
    access(1'b0, 1'b1, 32'h0000_0014, 32'h1111_1111, "st_idx5");

    // Store abandoned by a reset pulse during WAIT
    MemRead_MEM  = 1'b0;
    MemWrite_MEM = 1'b1;
    Addr         = 32'h0000_0014;
    WriteData    = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    check32("abort_in_wait", {31'd0, Stall}, 32'd1);
    rst          = 1'b0;
    MemWrite_MEM = 1'b0;
    @(negedge clk);
    #1;
    check32("abort_reset_stall", {31'd0, Stall}, 32'd0);
    check32("abort_reset_rdata", ReadData, 32'd0);
    last_read  = 32'd0;
    last_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, 32'h0000_0014, 32'd0, "ld_after_abort");

    // Read and write both asserted is a write
    access(1'b1, 1'b1, 32'h0000_001C, 32'h0F0F_0F0F, "both_idx7");
    access(1'b1, 1'b0, 32'h0000_001C, 32'd0,         "ld_idx7");

    MemRead_MEM  = 1'b0;
    MemWrite_MEM = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check32("idle_stall", {31'd0, Stall}, 32'd0);
    check32("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
